// File: rtl/centurion_uart_pkg.sv
// Shared constants for the Centurion console UART transmitter.
// Optional even parity is enabled with the CENTURION_UART_PARITY_EN macro.
package centurion_uart_pkg;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_START  = 3'd1;
  localparam logic [2:0] ST_DATA   = 3'd2;
  localparam logic [2:0] ST_STOP   = 3'd3;
  localparam logic [2:0] ST_PARITY = 3'd4;

  localparam int unsigned STAT_READY    = 32'd0;
  localparam int unsigned STAT_DRAINED  = 32'd1;
  localparam int unsigned STAT_OVERFLOW = 32'd2;

  localparam logic [15:0] OFF_DATA   = 16'd0;
  localparam logic [15:0] OFF_STATUS = 16'd1;

`ifdef CENTURION_UART_PARITY_EN
  function automatic logic even_parity(input logic [7:0] data);
    return ^data;
  endfunction
`endif

endpackage

// File: rtl/centurion_uart_tx_if.sv
// CPU-side bus bundle for the console UART: address/write strobe in, read data out.
interface centurion_uart_tx_if;

  logic [15:0] address;
  logic        write_en;
  logic [7:0]  data_in;
  logic [7:0]  data_out;
  logic        selected;

  modport master (
    output address,
    output write_en,
    output data_in,
    input  data_out,
    input  selected
  );

  modport slave (
    input  address,
    input  write_en,
    input  data_in,
    output data_out,
    output selected
  );

endinterface

// File: rtl/centurion_sync_fifo.sv
// Single-clock FIFO; a push while full is accepted only when a pop happens in the same cycle.
module centurion_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW-1:0] PTR_ONE  = AW'(32'd1);
  localparam logic [AW:0]   CNT_ONE  = (AW+1)'(32'd1);
  localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [AW-1:0]    wr_ptr_r;
  logic [AW-1:0]    rd_ptr_r;
  logic [AW:0]      count_r;
  logic             do_push_s;
  logic             do_pop_s;
  logic             full_s;
  logic             empty_s;

  assign full_s    = (count_r == CNT_FULL);
  assign empty_s   = (count_r == {(AW+1){1'b0}});
  assign do_pop_s  = pop && !empty_s;
  assign do_push_s = push && (!full_s || do_pop_s);

  assign head  = mem_r[rd_ptr_r];
  assign full  = full_s;
  assign empty = empty_s;
  assign count = count_r;

  // Storage array; contents are don't-care until written.
  always_ff @(posedge clock) begin
    if (do_push_s) begin
      mem_r[wr_ptr_r] <= push_data;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      count_r  <= {(AW+1){1'b0}};
    end else begin
      if (do_push_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_ONE;
      end
      if (do_pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end
      case ({do_push_s, do_pop_s})
        2'b10:   count_r <= count_r + CNT_ONE;
        2'b01:   count_r <= count_r - CNT_ONE;
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: rtl/centurion_uart_tx.sv
// Memory-mapped console transmitter: data register at BASE_ADDR, status at BASE_ADDR+1.
// Build with CENTURION_UART_PARITY_EN to append an even-parity bit after the data bits.
module centurion_uart_tx
  import centurion_uart_pkg::*;
#(
  parameter logic [15:0] BASE_ADDR    = 16'hF200,
  parameter int          CLKS_PER_BIT = 16,
  parameter int          FIFO_DEPTH   = 8
) (
  input  logic                 clock,
  input  logic                 reset,
  centurion_uart_tx_if.slave   bus,
  output logic                 tx,
  output logic                 busy
);

  localparam int BW = $clog2(CLKS_PER_BIT);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [BW-1:0] BAUD_ZERO = {BW{1'b0}};
  localparam logic [BW-1:0] BAUD_ONE  = BW'(32'd1);
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] CNT_ONE   = CW'(32'd1);
`ifdef CENTURION_UART_PARITY_EN
  localparam logic [2:0] AFTER_DATA = ST_PARITY;
`else
  localparam logic [2:0] AFTER_DATA = ST_STOP;
`endif

  logic          sel_data_s;
  logic          sel_stat_s;
  logic          push_req_s;
  logic          push_ok_s;
  logic          stat_wr_s;
  logic [7:0]    fifo_head_s;
  logic          fifo_full_s;
  logic          fifo_empty_s;
  logic [CW-1:0] fifo_count_s;
  logic          pop_s;
  logic          baud_done_s;
  logic          nonempty_next_s;
  logic [7:0]    status_s;

  logic [2:0]    state_r;
  logic [2:0]    state_next_s;
  logic [BW-1:0] baud_r;
  logic [BW-1:0] baud_next_s;
  logic [2:0]    bit_idx_r;
  logic [2:0]    bit_next_s;
  logic [7:0]    shift_r;
  logic [7:0]    shift_next_s;
  logic          tx_r;
  logic          tx_next_s;
  logic          busy_r;
  logic          busy_next_s;
  logic          overflow_r;
`ifdef CENTURION_UART_PARITY_EN
  logic          parity_r;
`endif

  assign sel_data_s  = (bus.address == (BASE_ADDR + OFF_DATA));
  assign sel_stat_s  = (bus.address == (BASE_ADDR + OFF_STATUS));
  assign push_req_s  = bus.write_en && sel_data_s;
  assign stat_wr_s   = bus.write_en && sel_stat_s;
  assign push_ok_s   = push_req_s && (!fifo_full_s || pop_s);
  assign baud_done_s = (baud_r == BAUD_LAST);

  assign bus.selected = sel_data_s || sel_stat_s;
  assign tx   = tx_r;
  assign busy = busy_r;

  centurion_sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clock     (clock),
    .reset     (reset),
    .push      (push_req_s),
    .push_data (bus.data_in),
    .pop       (pop_s),
    .head      (fifo_head_s),
    .full      (fifo_full_s),
    .empty     (fifo_empty_s),
    .count     (fifo_count_s)
  );

  // Status register image.
  always_comb begin
    status_s                = 8'h00;
    status_s[STAT_READY]    = !fifo_full_s;
    status_s[STAT_DRAINED]  = fifo_empty_s && (state_r == ST_IDLE);
    status_s[STAT_OVERFLOW] = overflow_r;
  end

  // Read mux: only the status register returns non-zero data.
  always_comb begin
    if (sel_stat_s) begin
      bus.data_out = status_s;
    end else begin
      bus.data_out = 8'h00;
    end
  end

  // Framer next-state: IDLE pops the FIFO head, then START, DATA (LSB first), [PARITY], STOP.
  always_comb begin
    state_next_s = state_r;
    baud_next_s  = baud_r;
    bit_next_s   = bit_idx_r;
    shift_next_s = shift_r;
    pop_s        = 1'b0;
    case (state_r)
      ST_IDLE: begin
        baud_next_s = BAUD_ZERO;
        if (!fifo_empty_s) begin
          pop_s        = 1'b1;
          shift_next_s = fifo_head_s;
          bit_next_s   = 3'd0;
          state_next_s = ST_START;
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_START: begin
        if (baud_done_s) begin
          baud_next_s  = BAUD_ZERO;
          bit_next_s   = 3'd0;
          state_next_s = ST_DATA;
        end else begin
          baud_next_s = baud_r + BAUD_ONE;
        end
      end
      ST_DATA: begin
        if (baud_done_s) begin
          baud_next_s  = BAUD_ZERO;
          shift_next_s = {1'b0, shift_r[7:1]};
          if (bit_idx_r == 3'd7) begin
            state_next_s = AFTER_DATA;
          end else begin
            bit_next_s = bit_idx_r + 3'd1;
          end
        end else begin
          baud_next_s = baud_r + BAUD_ONE;
        end
      end
`ifdef CENTURION_UART_PARITY_EN
      ST_PARITY: begin
        if (baud_done_s) begin
          baud_next_s  = BAUD_ZERO;
          state_next_s = ST_STOP;
        end else begin
          baud_next_s = baud_r + BAUD_ONE;
        end
      end
`endif
      ST_STOP: begin
        if (baud_done_s) begin
          baud_next_s  = BAUD_ZERO;
          state_next_s = ST_IDLE;
        end else begin
          baud_next_s = baud_r + BAUD_ONE;
        end
      end
      default: begin
        baud_next_s  = BAUD_ZERO;
        state_next_s = ST_IDLE;
      end
    endcase
  end

  // Line level for the upcoming state, so tx comes straight from a flop.
  always_comb begin
    case (state_next_s)
      ST_START:  tx_next_s = 1'b0;
      ST_DATA:   tx_next_s = shift_next_s[0];
`ifdef CENTURION_UART_PARITY_EN
      ST_PARITY: tx_next_s = parity_r;
`endif
      default:   tx_next_s = 1'b1;
    endcase
  end

  // Busy looks ahead at FIFO occupancy and framer state after this edge.
  always_comb begin
    if (push_ok_s) begin
      nonempty_next_s = 1'b1;
    end else if (pop_s) begin
      nonempty_next_s = (fifo_count_s > CNT_ONE);
    end else begin
      nonempty_next_s = !fifo_empty_s;
    end
    busy_next_s = nonempty_next_s || (state_next_s != ST_IDLE);
  end

  // Framer registers; reset forces the line high immediately.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_r   <= ST_IDLE;
      baud_r    <= BAUD_ZERO;
      bit_idx_r <= 3'd0;
      shift_r   <= 8'h00;
      tx_r      <= 1'b1;
      busy_r    <= 1'b0;
    end else begin
      state_r   <= state_next_s;
      baud_r    <= baud_next_s;
      bit_idx_r <= bit_next_s;
      shift_r   <= shift_next_s;
      tx_r      <= tx_next_s;
      busy_r    <= busy_next_s;
    end
  end

`ifdef CENTURION_UART_PARITY_EN
  // Parity is captured with the byte so it is ready when DATA finishes.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      parity_r <= 1'b0;
    end else if (pop_s) begin
      parity_r <= even_parity(fifo_head_s);
    end else begin
      parity_r <= parity_r;
    end
  end
`endif

  // Sticky overflow: set by a dropped push, cleared by any status write.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      overflow_r <= 1'b0;
    end else if (stat_wr_s) begin
      overflow_r <= 1'b0;
    end else if (push_req_s && !push_ok_s) begin
      overflow_r <= 1'b1;
    end else begin
      overflow_r <= overflow_r;
    end
  end

endmodule

// File: tb/tb_centurion_uart_tx.sv
// Scoreboard bench for centurion_uart_tx: timeline model predicts frames, line monitor decodes them.
module tb_centurion_uart_tx;

  localparam int          CPB   = 4;
  localparam int          DEPTH = 8;
  localparam logic [15:0] BASE  = 16'hF200;
  localparam logic [15:0] STAT  = 16'hF201;
`ifdef CENTURION_UART_PARITY_EN
  localparam int NBITS = 11;
`else
  localparam int NBITS = 10;
`endif
  localparam int FRAME_CLKS = NBITS * CPB;

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic tx;
  logic busy;

  centurion_uart_tx_if bus ();

  centurion_uart_tx #(
    .BASE_ADDR    (BASE),
    .CLKS_PER_BIT (CPB),
    .FIFO_DEPTH   (DEPTH)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus),
    .tx    (tx),
    .busy  (busy)
  );

  always #5 clock = ~clock;

  int cycle_cnt = 0;
  always @(posedge clock) cycle_cnt <= cycle_cnt + 1;

  typedef struct {
    logic [7:0] data;
    int         start;
  } frame_t;

  int         n_tests = 0;
  int         n_fail  = 0;
  frame_t     exp_q[$];
  logic [7:0] mq[$];
  int         frame_end = -1;
  bit         ovf_m = 1'b0;
  bit         mon_en = 1'b0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, got, want, cycle_cnt);
    end
  endtask

  function automatic logic [7:0] model_status(input int e);
    logic [7:0] s;
    s    = 8'h00;
    s[0] = (mq.size() < DEPTH);
    s[1] = (mq.size() == 0) && (e >= frame_end);
    s[2] = ovf_m;
    return s;
  endfunction

  // One clock: drive inputs, advance the model across the coming edge, check after it.
  task automatic tick(input logic [15:0] addr, input logic we, input logic [7:0] din);
    int         e;
    int         sz;
    bit         pop;
    frame_t     f;
    logic [7:0] st;
    bus.address  = addr;
    bus.write_en = we;
    bus.data_in  = din;
    e   = cycle_cnt + 1;
    sz  = mq.size();
    pop = (sz > 0) && (e > frame_end);
    if (we && addr == BASE) begin
      if (sz < DEPTH || pop) mq.push_back(din);
      else ovf_m = 1'b1;
    end
    if (we && addr == STAT) ovf_m = 1'b0;
    if (pop) begin
      f.data  = mq.pop_front();
      f.start = e;
      exp_q.push_back(f);
      frame_end = e + FRAME_CLKS;
    end
    @(negedge clock);
    st = model_status(e);
    check("busy", busy, (mq.size() > 0) || (e < frame_end));
    check("selected", bus.selected, (addr == BASE) || (addr == STAT));
    check("data_out", bus.data_out, (addr == STAT) ? st : 8'h00);
  endtask

  task automatic drain();
    int guard;
    guard = 0;
    while ((mq.size() != 0 || cycle_cnt < frame_end + 2) && guard < 3000) begin
      tick(16'h0000, 1'b0, 8'h00);
      guard++;
    end
    check("drain_bound", guard < 3000, 1'b1);
    check("frames_outstanding", exp_q.size(), 0);
  endtask

  // Line receiver: decodes each frame and scores it against the expected queue.
  initial begin : monitor
    logic       line [NBITS*CPB];
    int         s;
    bit         shape_ok;
    logic [7:0] rx;
    frame_t     f;
    forever begin
      @(negedge clock);
      if (mon_en && tx === 1'b0) begin
        s       = cycle_cnt;
        line[0] = tx;
        for (int k = 1; k < NBITS * CPB; k++) begin
          @(negedge clock);
          line[k] = tx;
        end
        shape_ok = 1'b1;
        for (int j = 0; j < NBITS; j++) begin
          for (int k = 1; k < CPB; k++) begin
            if (line[j*CPB+k] !== line[j*CPB]) shape_ok = 1'b0;
          end
        end
        for (int i = 0; i < 8; i++) rx[i] = line[(i+1)*CPB];
        check("bit_shape", shape_ok, 1'b1);
        check("stop_bit", line[(NBITS-1)*CPB], 1'b1);
        check("frame_expected", exp_q.size() != 0, 1'b1);
        if (exp_q.size() != 0) begin
          f = exp_q.pop_front();
          check("rx_byte", rx, f.data);
          check("start_cycle", s, f.start);
`ifdef CENTURION_UART_PARITY_EN
          check("parity_bit", line[9*CPB], ^f.data);
`endif
        end
      end
    end
  end

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int         n0;
    int         d;
    int         j;
    int         r;
    int         guard;
    logic       exp_tx;
    logic [7:0] b;

    bus.address  = 16'h0000;
    bus.write_en = 1'b0;
    bus.data_in  = 8'h00;
    reset        = 1'b1;
    repeat (2) @(negedge clock);
    bus.address = STAT;
    #1;
    check("reset_tx", tx, 1'b1);
    check("reset_busy", busy, 1'b0);
    check("reset_status", bus.data_out, 8'h03);
    @(negedge clock);
    reset = 1'b0;

    // Reset in the middle of a start bit.
    tick(BASE, 1'b1, 8'h55);
    tick(STAT, 1'b0, 8'h00);
    tick(STAT, 1'b0, 8'h00);
    check("start_low", tx, 1'b0);
    #1 reset = 1'b1;
    #1;
    check("abort_tx", tx, 1'b1);
    check("abort_busy", busy, 1'b0);
    check("abort_status", bus.data_out, 8'h03);
    @(negedge clock);
    reset = 1'b0;
    mq.delete();
    exp_q.delete();
    frame_end = -1;
    ovf_m     = 1'b0;
    mon_en    = 1'b1;

    // Single byte: exact line pattern and busy timing.
    b = 8'h48;
    tick(BASE, 1'b1, b);
    n0 = cycle_cnt;
    check("tx_idle_after_push", tx, 1'b1);
    for (int i = 0; i < FRAME_CLKS + 4; i++) begin
      tick(16'h0000, 1'b0, 8'h00);
      d = cycle_cnt - n0;
      j = (d - 1) / CPB;
      if (j == 0) exp_tx = 1'b0;
      else if (j <= 8) exp_tx = b[j-1];
`ifdef CENTURION_UART_PARITY_EN
      else if (j == 9) exp_tx = ^b;
`endif
      else exp_tx = 1'b1;
      check("pattern_48", tx, exp_tx);
      if (d == FRAME_CLKS) check("busy_before_end", busy, 1'b1);
      if (d == FRAME_CLKS + 1) check("busy_fall", busy, 1'b0);
    end
    drain();

    // Overflow while a frame is in progress, then clear via status write.
    tick(BASE, 1'b1, 8'hA5);
    repeat (3) tick(16'h0000, 1'b0, 8'h00);
    for (int i = 0; i < 9; i++) tick(BASE, 1'b1, 8'(8'h30 + i));
    tick(STAT, 1'b0, 8'h00);
    check("ovf_status", bus.data_out, 8'h04);
    tick(STAT, 1'b1, 8'h00);
    tick(STAT, 1'b0, 8'h00);
    check("ovf_cleared", bus.data_out, 8'h00);
    drain();
    tick(STAT, 1'b0, 8'h00);
    check("drained_status", bus.data_out, 8'h03);

    // Back-to-back "HI": start cycles checked by the monitor.
    tick(BASE, 1'b1, 8'h48);
    tick(BASE, 1'b1, 8'h49);
    drain();

    // Full FIFO with a push landing on the pop edge.
    tick(BASE, 1'b1, 8'hC3);
    repeat (2) tick(16'h0000, 1'b0, 8'h00);
    for (int i = 0; i < DEPTH; i++) tick(BASE, 1'b1, 8'($urandom));
    guard = 0;
    while (cycle_cnt + 1 < frame_end + 1 && guard < 200) begin
      tick(16'h0000, 1'b0, 8'h00);
      guard++;
    end
    check("pop_edge_bound", guard < 200, 1'b1);
    tick(BASE, 1'b1, 8'h7E);
    tick(STAT, 1'b0, 8'h00);
    check("full_pop_status", bus.data_out, 8'h00);
    drain();

    // Randomised traffic over data, status and unrelated addresses.
    for (int i = 0; i < 400; i++) begin
      r = int'($urandom_range(0, 9));
      case (r)
        0, 1, 2: tick(BASE, 1'b1, 8'($urandom));
        3:       tick(STAT, 1'b1, 8'($urandom));
        4, 5:    tick(STAT, 1'b0, 8'h00);
        6:       tick(16'($urandom), 1'($urandom), 8'($urandom));
        7:       tick(BASE, 1'b0, 8'($urandom));
        default: tick(16'hF202, 1'b1, 8'($urandom));
      endcase
    end
    drain();

`ifdef CENTURION_UART_PARITY_EN
    tick(BASE, 1'b1, 8'h07);
    drain();
    tick(BASE, 1'b1, 8'h03);
    drain();
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/centurion_uart_tx.md
Name: centurion_uart_tx

Overview:
- Memory-mapped serial transmitter, downstream of CPU6 on the shared bus; consumes CPU byte writes to the console address.
- Replaces the bench's "$write on 0xF200" stand-in with real 8N1 serial output, a transmit FIFO and a readable status register.
- Bench or top level muxes its data_out onto the CPU read bus when `selected` is high.

Parameters:
- BASE_ADDR, 16'hF200, data register address; BASE_ADDR+1 is the status register.
- CLKS_PER_BIT, 16, clock cycles per serial bit; must be >= 2.
- FIFO_DEPTH, 8, transmit FIFO entries; must be a power of two, >= 2.

Ports:
- clock  in  1  system clock; all state updates on posedge.
- reset  in  1  asynchronous, active-high.
- address  in  16  CPU address bus.
- write_en  in  1  CPU write strobe, sampled on posedge clock.
- data_in  in  8  CPU write data.
- data_out  out  8  combinational read data, valid while `selected` is high, else 8'h00.
- selected  out  1  combinational: address == BASE_ADDR or BASE_ADDR+1.
- tx  out  1  serial line; idle high.
- busy  out  1  high while the FIFO is non-empty or a frame is in progress.

Behaviour:
- Reset (async, active-high): FIFO empty, pointers 0; state IDLE; bit and baud counters 0; overflow flag 0; tx=1; busy=0. Reset mid-frame aborts immediately and tx returns to 1 with no glitch low.
- Push: write_en && address==BASE_ADDR at posedge. Accepted if FIFO not full, or if a pop occurs in the same cycle (count unchanged).
  - When full with no pop: byte dropped; overflow flag set (sticky).
- Status read at BASE_ADDR+1 (data_out):
  - bit0 = not full (ready).
  - bit1 = FIFO empty && state IDLE (drained).
  - bit2 = overflow.
  - bits7:3 = 0.
- Data read at BASE_ADDR returns 8'h00.
- Any write to BASE_ADDR+1 clears overflow.
- Serial FSM states: IDLE, START, DATA, STOP.
  - IDLE: if FIFO non-empty, pop the head into the shift register, reset the baud counter, go to START. tx=1.
  - START: tx=0 for CLKS_PER_BIT cycles, then go to DATA with bit index 0.
  - DATA: tx=shift[0], LSB first, CLKS_PER_BIT cycles per bit. After bit 7 go to STOP.
  - STOP: tx=1 for CLKS_PER_BIT cycles, then go to IDLE.
- Latency: a push at edge N makes the FIFO non-empty after N. The pop happens at edge N+1, and tx falls after edge N+1.
- Back-to-back: STOP goes to IDLE, and IDLE pops on its first cycle. Inter-frame gap is exactly 1 clock of extra idle-high.
- Frame length: 10*CLKS_PER_BIT clocks, plus 1 IDLE clock.
- Baud counter counts 0..CLKS_PER_BIT-1 and wraps; width is $clog2(CLKS_PER_BIT).
- FIFO pointers wrap modulo FIFO_DEPTH. Count is $clog2(FIFO_DEPTH)+1 bits.
- Simultaneous push and status-clear write is impossible (different addresses). A push while the FIFO is empty and IDLE is never bypassed; it always goes through the FIFO.

Optional Feature:
- Macro: CENTURION_UART_PARITY_EN.
- With the macro: an even-parity bit (XOR of data bits) is sent after bit 7, in state PARITY, for CLKS_PER_BIT cycles. Frame = 11*CLKS_PER_BIT.
- Without the macro: no PARITY state, 8N1 frame, and the parity logic is absent from the netlist.

Decomposition:
- Shared package centurion_uart_pkg holds:
  - FSM state encoding (IDLE=0, START=1, DATA=2, STOP=3, PARITY=4).
  - Status bit positions (STAT_READY=0, STAT_DRAINED=1, STAT_OVERFLOW=2).
  - Register offsets (OFF_DATA=0, OFF_STATUS=1).
- One sub-module, centurion_sync_fifo: parameterised width and depth; push/pop/full/empty/count. Same async active-high reset.

Test Plan (CLKS_PER_BIT=4, FIFO_DEPTH=8):
- Reset while tx is low mid-START → tx=1, busy=0, status=8'h03 one delta after reset rises.
- Write 8'h48 to F200 → tx low from edge N+1 for 4 clocks. Then the bit pattern 0,0,0,1,0,0,1,0, 4 clocks each, then high. busy falls 41 clocks after the push.
- Write 9 bytes in 9 consecutive cycles with the FSM already mid-frame → 8 accepted, 9th dropped. Status reads 8'h04 (not ready, overflow). After a write to F201 it reads 8'h00.
- Write "HI" back-to-back → two frames separated by exactly 1 extra idle-high clock. Receiver model decodes 8'h48, 8'h49.
- Full FIFO plus a push in the pop cycle → byte accepted, count stays 8, overflow stays 0.
- With CENTURION_UART_PARITY_EN: send 8'h07 → parity bit 1, frame 44 clocks. Send 8'h03 → parity bit 0.
